// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter
//   Source-domain scheduler for one shared DATA_SYNC crossing channel.
//   Requesters are granted round-robin. The winning word is placed on
//   Unsync_bus. Unsync_enable is then held high for HOLD_CYCLES, followed by
//   GAP_CYCLES of low. This lets the destination synchroniser see exactly one
//   rising enable per word.
//
// Handshake: requester i holds req[i] high with its word stable on
//   req_data[i*DATA_WIDTH +: DATA_WIDTH] until it sees gnt[i]. gnt[i] is a
//   registered one-cycle pulse in the cycle the word is taken. The requester
//   may drop req[i] in that cycle. If req[i] is still high afterwards, it is
//   treated as a new word. req is only sampled while the FSM is IDLE.
//
// Ports
//   D_CLK          source clock, rising edge
//   D_RST          synchronous active-high reset
//   req            per-requester request
//   req_data       packed request words
//   gnt            one-hot accept pulse (registered)
//   Unsync_bus     word presented to DATA_SYNC (stable between grants)
//   Unsync_enable  enable level to DATA_SYNC
//   src_id         index of requester owning Unsync_bus
//   busy           high whenever the FSM is not IDLE (state visibility)
module cdc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int ID_WIDTH    = 2
) (
  input  logic                          D_CLK,
  input  logic                          D_RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         Unsync_bus,
  output logic                          Unsync_enable,
  output logic [ID_WIDTH-1:0]           src_id,
  output logic                          busy
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;       // shared HOLD/GAP down-counter
  logic [PW-1:0]   ptr;       // round-robin priority pointer
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic            found;
  logic [PW-1:0]   ptr_next;

  // Start at ptr and scan upward with wrap-around. The first set request wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ptr_next = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

  always_ff @(posedge D_CLK) begin
    if (D_RST) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= '0;
      gnt           <= '0;
      Unsync_bus    <= '0;
      Unsync_enable <= 1'b0;
      src_id        <= '0;
      busy          <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state         <= HOLD;
            cnt           <= CW'(HOLD_CYCLES);
            ptr           <= ptr_next;
            gnt           <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            Unsync_bus    <= req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            src_id        <= ID_WIDTH'(pick);
            Unsync_enable <= 1'b1;
            busy          <= 1'b1;
          end else begin
            Unsync_enable <= 1'b0;
          end
        end
        HOLD: begin
          // The counter was loaded with HOLD_CYCLES on the grant edge. The
          // level therefore spans that many cycles when the exit happens at 1.
          if (cnt == CW'(1)) begin
            state         <= GAP;
            cnt           <= CW'(GAP_CYCLES);
            Unsync_enable <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          Unsync_enable <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
module tb_cdc_tx_arbiter;

  logic        D_CLK = 1'b0;
  logic        D_RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  Unsync_bus;
  logic        Unsync_enable;
  logic [1:0]  src_id;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  // clock / reset
  always #5 D_CLK = ~D_CLK;

  cdc_tx_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .HOLD_CYCLES(3), .GAP_CYCLES(2), .ID_WIDTH(2)
  ) dut (
    .D_CLK(D_CLK), .D_RST(D_RST), .req(req), .req_data(req_data),
    .gnt(gnt), .Unsync_bus(Unsync_bus), .Unsync_enable(Unsync_enable),
    .src_id(src_id), .busy(busy)
  );

  // Destination DATA_SYNC model: N_STAGES=2, same clock, one pulse per rising
  // synchronised enable, bus captured alongside the pulse.
  logic       s1, s2, s2_d, enable_pulse;
  logic [7:0] sync_bus;
  always_ff @(posedge D_CLK) begin
    if (D_RST) begin
      s1 <= 1'b0; s2 <= 1'b0; s2_d <= 1'b0; enable_pulse <= 1'b0; sync_bus <= '0;
    end else begin
      s1 <= Unsync_enable;
      s2 <= s1;
      s2_d <= s2;
      enable_pulse <= s2 & ~s2_d;
      if (s2 & ~s2_d) sync_bus <= Unsync_bus;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge D_CLK);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    D_RST = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      req = 4'($urandom_range(0, 15));
      step();
    end
    D_RST = 1'b0;
    req   = 4'b0000;
  endtask

  // Step until any gnt appears; cyc returns the number of steps taken.
  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (gnt == 4'b0000 && cyc < 30);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 30) begin
      step();
      c++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [3:0] exp_order [4];
    D_RST    = 1'b1;
    req      = 4'b0000;
    req_data = '0;

    // 1. reset with random requests
    do_reset(2);
    chk("rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("rst_en",   {31'd0, Unsync_enable}, 32'd0);
    chk("rst_bus",  {24'd0, Unsync_bus}, 32'h00);
    chk("rst_src",  {30'd0, src_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    chk("idle_gnt", {28'd0, gnt}, 32'd0);

    // 2. single request from requester 1
    req_data[15:8] = 8'hAA;
    req = 4'b0010;
    step();                                   // t+1
    req = 4'b0000;
    chk("s_gnt1",  {28'd0, gnt}, 32'h2);
    chk("s_en1",   {31'd0, Unsync_enable}, 32'd1);
    chk("s_bus1",  {24'd0, Unsync_bus}, 32'hAA);
    chk("s_src1",  {30'd0, src_id}, 32'd1);
    chk("s_busy1", {31'd0, busy}, 32'd1);
    step();                                   // t+2
    chk("s_gnt2",  {28'd0, gnt}, 32'd0);
    chk("s_en2",   {31'd0, Unsync_enable}, 32'd1);
    step();                                   // t+3
    chk("s_en3",   {31'd0, Unsync_enable}, 32'd1);
    step();                                   // t+4
    chk("s_en4",   {31'd0, Unsync_enable}, 32'd0);
    chk("s_busy4", {31'd0, busy}, 32'd1);
    step();                                   // t+5
    chk("s_en5",   {31'd0, Unsync_enable}, 32'd0);
    chk("s_busy5", {31'd0, busy}, 32'd1);
    step();                                   // t+6
    chk("s_busy6", {31'd0, busy}, 32'd0);
    chk("s_bus6",  {24'd0, Unsync_bus}, 32'hAA);
    step();                                   // idle, no req: outputs hold
    chk("s_hold_bus", {24'd0, Unsync_bus}, 32'hAA);
    chk("s_hold_src", {30'd0, src_id}, 32'd1);
    chk("s_hold_en",  {31'd0, Unsync_enable}, 32'd0);

    // 3. all four requesting after reset, each dropped on its gnt
    do_reset(1);
    req_data = 32'h13121110;
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(cyc);
      chk($sformatf("all_gnt%0d", n), {28'd0, gnt}, 32'd1 << n);
      chk($sformatf("all_bus%0d", n), {24'd0, Unsync_bus}, 32'h10 + n);
      chk($sformatf("all_src%0d", n), {30'd0, src_id}, n);
      if (n > 0) chk($sformatf("all_gap%0d", n), cyc, 32'd6);
      req = req & ~gnt;
    end
    wait_idle();

    // 4. fairness: req0 and req2 held continuously (ptr is 0 here)
    req_data = 32'h00220020;
    req = 4'b0101;
    exp_order = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int n = 0; n < 4; n++) begin
      wait_gnt(cyc);
      chk($sformatf("fair_gnt%0d", n), {28'd0, gnt}, {28'd0, exp_order[n]});
      chk($sformatf("fair_bus%0d", n), {24'd0, Unsync_bus},
          (exp_order[n] == 4'b0001) ? 32'h20 : 32'h22);
    end
    req = 4'b0000;
    wait_idle();

    // 5. reset in the second HOLD cycle; ptr must return to 0
    req_data = 32'h30000033;
    req = 4'b0100;
    step();                                   // grant, HOLD cycle 1
    chk("mr_gnt", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    step();                                   // HOLD cycle 2
    chk("mr_en_hold", {31'd0, Unsync_enable}, 32'd1);
    D_RST = 1'b1;
    req = 4'b1001;
    step();
    chk("mr_en",   {31'd0, Unsync_enable}, 32'd0);
    chk("mr_gnt0", {28'd0, gnt}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    D_RST = 1'b0;
    wait_gnt(cyc);
    chk("mr_first_gnt", {28'd0, gnt}, 32'h1);
    chk("mr_first_lat", cyc, 32'd1);
    chk("mr_first_bus", {24'd0, Unsync_bus}, 32'h33);
    req = 4'b1000;
    wait_gnt(cyc);
    chk("mr_second_gnt", {28'd0, gnt}, 32'h8);
    chk("mr_second_src", {30'd0, src_id}, 32'd3);
    req = 4'b0000;
    wait_idle();

    // 6. end-to-end through the DATA_SYNC model
    do_reset(1);
    req_data = 32'h00FFA555;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hFF);
    req = 4'b0111;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      req = req & ~gnt;
      if (enable_pulse) begin
        pulses++;
        if (exp_q.size() > 0) chk("e2e_word", {24'd0, sync_bus}, {24'd0, exp_q.pop_front()});
        else chk("e2e_extra_pulse", pulses, 32'd3);
      end
    end
    chk("e2e_pulses", pulses, 32'd3);
    chk("e2e_left", exp_q.size(), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
